act_lut_loader: RTL and testbench

ACT_LUT_LOADER -- requirements
Module: act_lut_loader

---
 rtl/act_lut_loader.sv | 201 ++++++++++++++++++++
 tb/tb_act_lut_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lut_loader.sv
// rtl/act_lut_loader.sv - streams coefficient words into one bank of the activation LUT
//
// Purpose:
//   Accepts a load request (bank mask, base entry, entry count), then takes one
//   {a_coef, b_coef} word per handshake from a valid/ready stream. Each word is
//   turned into a registered LUT write strobe one cycle later, at consecutive
//   entry addresses that wrap within the bank. A running XOR checksum of the
//   written words is kept. A load can be cancelled with abort.
//
// Ports:
//   clk              in   1          sole clock, rising edge
//   rst_n            in   1          asynchronous active-low reset
//   start            in   1          load request, honoured only in IDLE
//   cfg_mask         in   MASK_W     target bank, captured on accepted start
//   cfg_base         in   ADDR_W     first entry address, captured on accepted start
//   cfg_count        in   ADDR_W+1   entries to load (0 or >2^ADDR_W -> 2^ADDR_W)
//   abort            in   1          cancel an active load
//   in_valid         in   1          coefficient word valid
//   in_data          in   DATA_W     coefficient word
//   in_ready         out  1          loader accepts a word this cycle (state == LOAD)
//   lut_write_enable out  1          LUT write strobe
//   lut_mask         out  MASK_W     bank mask, held from start until next start
//   lut_write_addr   out  ADDR_W     entry address within the bank
//   lut_write_data   out  DATA_W     entry written
//   busy             out  1          load in progress
//   done             out  1          one-cycle pulse on successful completion
//   aborted          out  1          sticky: last load was aborted
//   checksum         out  DATA_W     XOR of all words written by the current/last load

package act_lut_pkg;
  parameter int ACT_MASK_SIZE = 4;
  parameter int ACT_LUT_DEPTH = 4;
  parameter int ACT_LUT_SIZE  = 32;
endpackage

module act_lut_loader
  import act_lut_pkg::*;
#(
  parameter int MASK_W = ACT_MASK_SIZE,
  parameter int ADDR_W = ACT_LUT_DEPTH,
  parameter int DATA_W = ACT_LUT_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MASK_W-1:0] cfg_mask,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              lut_write_enable,
  output logic [MASK_W-1:0] lut_mask,
  output logic [ADDR_W-1:0] lut_write_addr,
  output logic [DATA_W-1:0] lut_write_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One full bank worth of entries: 2^ADDR_W.
  localparam logic [ADDR_W:0]   L_FULL    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   L_REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] L_ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_addr;       // next entry to be written
  logic [ADDR_W:0]     r_remaining;  // entries still to accept in this load
  logic [MASK_W-1:0]   r_mask;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic [DATA_W-1:0]   r_checksum;

  logic                w_in_load;
  logic                w_start_acc;
  logic                w_handshake;
  logic                w_abort;
  logic                w_write;
  logic                w_last;
  logic [ADDR_W:0]     w_count_sat;

  assign w_in_load   = (r_state == ST_LOAD);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_handshake = w_in_load && in_valid;
  assign w_abort     = w_in_load && abort;
  // A word that arrives in the same cycle as abort is dropped on the floor.
  assign w_write     = w_handshake && !abort;
  assign w_last      = w_write && (r_remaining == L_REM_ONE);

  // Zero and anything beyond one bank both mean "fill the whole bank".
  assign w_count_sat = ((cfg_count == '0) || (cfg_count > L_FULL)) ? L_FULL : cfg_count;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_mask      <= '0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_we   <= w_write;
      // done is raised on the same edge as the final write strobe, so both
      // are seen together while the FSM sits in DONE.
      r_done <= w_last;
      r_busy <= (w_next_state != ST_IDLE);

      if (w_start_acc) begin
        r_mask      <= cfg_mask;
        r_addr      <= cfg_base;
        r_remaining <= w_count_sat;
        r_checksum  <= '0;
        r_aborted   <= 1'b0;
      end

      if (w_write) begin
        r_wr_addr   <= r_addr;
        r_wr_data   <= in_data;
        r_addr      <= r_addr + L_ADR_ONE;  // wraps naturally within the bank
        r_remaining <= r_remaining - L_REM_ONE;
        r_checksum  <= r_checksum ^ in_data;
      end

      if (w_abort) begin
        r_aborted <= 1'b1;
      end
    end
  end

  // in_ready is the only combinational output; it tracks the state register,
  // so an asserted reset drops it at once along with everything else.
  assign in_ready         = w_in_load;
  assign lut_write_enable = r_we;
  assign lut_mask         = r_mask;
  assign lut_write_addr   = r_wr_addr;
  assign lut_write_data   = r_wr_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign aborted          = r_aborted;
  assign checksum         = r_checksum;

endmodule

// File: tb/tb_act_lut_loader.sv
// tb/tb_act_lut_loader.sv - scoreboard bench for act_lut_loader (ADDR_W=4, DATA_W=32)
module tb_act_lut_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_mask;
  logic [3:0]  cfg_base;
  logic [4:0]  cfg_count;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        lut_write_enable;
  logic [3:0]  lut_mask;
  logic [3:0]  lut_write_addr;
  logic [31:0] lut_write_data;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  act_lut_loader #(.MASK_W(4), .ADDR_W(4), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_mask         (cfg_mask),
    .cfg_base         (cfg_base),
    .cfg_count        (cfg_count),
    .abort            (abort),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .lut_write_enable (lut_write_enable),
    .lut_mask         (lut_mask),
    .lut_write_addr   (lut_write_addr),
    .lut_write_data   (lut_write_data),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .checksum         (checksum)
  );

  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  logic [31:0] exp_cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic void push(input logic [3:0] m, input logic [3:0] a,
                               input logic [31:0] d, input logic l);
    exp_t e;
    e.mask = m; e.addr = a; e.data = d; e.last = l;
    exp_q.push_back(e);
  endfunction

  // Monitor: compares every write strobe against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("stray_strobe", 32'(lut_write_enable), 32'd0);
    end else if (lut_write_enable) begin
      e = exp_q.pop_front();
      chk("wr_addr", 32'(lut_write_addr), 32'(e.addr));
      chk("wr_data", lut_write_data, e.data);
      chk("wr_mask", 32'(lut_mask), 32'(e.mask));
      chk("done_with_strobe", 32'(done), 32'(e.last));
    end
    if (!lut_write_enable) chk("done_without_strobe", 32'(done), 32'd0);
    if (done) n_done++;
  end

  task automatic do_start(input logic [3:0] m, input logic [3:0] b, input logic [4:0] c);
    cfg_mask = m; cfg_base = b; cfg_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_cs = 32'd0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_aborted_clr", 32'(aborted), 32'd0);
    chk("start_checksum_clr", checksum, 32'd0);
  endtask

  // Present one word, wait for acceptance; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input bit gap, input bit ab);
    int t;
    in_valid = 1'b1; in_data = d; abort = ab;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("handshake_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    if (!ab) exp_cs = exp_cs ^ d;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Called right after the final accepting edge.
  task automatic finish_check(input string tag);
    in_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_checksum"}, checksum, exp_cs);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd0);
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[4];
    logic [3:0]  addrs[4];
    int          d0;

    rst_n = 1'b0; start = 1'b0; cfg_mask = '0; cfg_base = '0; cfg_count = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full bank, constant valid, words 1..16.
    do_start(4'd2, 4'd0, 5'd16);
    for (int i = 1; i <= 16; i++) begin
      push(4'd2, 4'(i - 1), 32'(i), i == 16);
      send(32'(i), 1'b0, 1'b0);
    end
    chk("t1_checksum_const", checksum, 32'h0000_0010);
    finish_check("t1");

    // Wrap from 15 to 0.
    words = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003, 32'hF0F0_0004};
    addrs = '{4'd14, 4'd15, 4'd0, 4'd1};
    d0 = n_done;
    do_start(4'd6, 4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      push(4'd6, addrs[i], words[i], i == 3);
      send(words[i], 1'b0, 1'b0);
    end
    finish_check("t2");
    chk("t2_done_once", 32'(n_done - d0), 32'd1);

    // Toggling valid, start pulsed mid-load is ignored.
    do_start(4'd5, 4'd7, 5'd3);
    push(4'd5, 4'd7, 32'h1111_0000, 1'b0);
    send(32'h1111_0000, 1'b1, 1'b0);
    cfg_mask = 4'hF; cfg_base = 4'd0; cfg_count = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push(4'd5, 4'd8, 32'h2222_0000, 1'b0);
    send(32'h2222_0000, 1'b1, 1'b0);
    push(4'd5, 4'd9, 32'h4444_0000, 1'b1);
    send(32'h4444_0000, 1'b0, 1'b0);
    chk("t3_checksum_const", checksum, 32'h7777_0000);
    finish_check("t3");
    chk("t3_mask_held", 32'(lut_mask), 32'd5);

    // Abort together with the third handshake.
    d0 = n_done;
    do_start(4'd1, 4'd0, 5'd8);
    push(4'd1, 4'd0, 32'h0000_00A1, 1'b0);
    send(32'h0000_00A1, 1'b0, 1'b0);
    push(4'd1, 4'd1, 32'h0000_00B2, 1'b0);
    send(32'h0000_00B2, 1'b0, 1'b0);
    send(32'h0000_00C3, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("t4_aborted", 32'(aborted), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_checksum", checksum, 32'h0000_0013);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(n_done - d0), 32'd0);
    chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    do_start(4'd1, 4'd4, 5'd1);
    push(4'd1, 4'd4, 32'hDEAD_BEEF, 1'b1);
    send(32'hDEAD_BEEF, 1'b0, 1'b0);
    finish_check("t4b");

    // Reset in the middle of a load.
    do_start(4'd3, 4'd2, 5'd10);
    for (int i = 0; i < 5; i++) begin
      push(4'd3, 4'(2 + i), 32'h0100_0000 + 32'(i), 1'b0);
      send(32'h0100_0000 + 32'(i), 1'b0, 1'b0);
    end
    in_data = 32'h0100_0005;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_we", 32'(lut_write_enable), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_aborted", 32'(aborted), 32'd0);
    chk("t5_mask", 32'(lut_mask), 32'd0);
    chk("t5_addr", 32'(lut_write_addr), 32'd0);
    chk("t5_data", lut_write_data, 32'd0);
    chk("t5_checksum", checksum, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_in_ready", 32'(in_ready), 32'd0);
    chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    // count=0 means a full bank.
    do_start(4'd7, 4'd3, 5'd0);
    for (int i = 0; i < 16; i++) begin
      push(4'd7, 4'(3 + i), 32'h7000_0000 | 32'(i * 3), i == 15);
      send(32'h7000_0000 | 32'(i * 3), 1'b0, 1'b0);
    end
    finish_check("t6a");

    // count=20 saturates to a full bank; valid stays high afterwards.
    do_start(4'd9, 4'd0, 5'd20);
    for (int i = 0; i < 16; i++) begin
      push(4'd9, 4'(i), 32'h9000_0100 + 32'(i), i == 15);
      send(32'h9000_0100 + 32'(i), 1'b0, 1'b0);
    end
    chk("t6b_done", 32'(done), 32'd1);
    in_data = 32'h9000_0110;
    @(posedge clk); #1;
    chk("t6b_busy_after", 32'(busy), 32'd0);
    chk("t6b_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t6b_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
